// File: rtl/fp_mul_seq.sv
// fp_mul_seq: iterative fp16 multiplier; shift-add significand product over 11 cycles,
// then one cycle to normalize, truncate and flag.
module fp_mul_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     opA,
    input  logic [EXP_W+MAN_W:0]     opB,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     product,
    output logic                     underflow,
    output logic                     overflow,
    output logic                     inexact
);
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int EMAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t state, nxt;
    logic sgn, zero;
    logic [EXP_W-1:0] ea, eb;
    logic [SW-1:0] ma, mb;
    logic [PW-1:0] acc;
    logic [3:0] cnt;
    logic [EW-1:0] e;
    logic [MAN_W-1:0] man;
    logic dropped, ovf, unf;
    logic [W-1:0] res;

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = in_valid ? MUL : IDLE;
            MUL: nxt = (cnt == 4'(MAN_W)) ? NORM : MUL;
            NORM: nxt = DONE;
            DONE: nxt = out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state <= nxt;
            in_ready <= (nxt == IDLE);
            out_valid <= (nxt == DONE);
        end
    end

    // e is signed EW bits so sums below zero or above EMAX never wrap into range
    always_comb begin
        man = acc[PW-1] ? acc[PW-2 -: MAN_W] : acc[PW-3 -: MAN_W];
        dropped = acc[PW-1] ? |acc[MAN_W:0] : |acc[MAN_W-1:0];
        e = EW'(ea) + EW'(eb) + EW'(acc[PW-1]) - EW'(BIAS);
        ovf = $signed(e) >= $signed(EW'(EMAX));
        unf = $signed(e) <= $signed(EW'(0));
        res = zero ? {sgn, {(W-1){1'b0}}} :
              ovf  ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
              unf  ? {sgn, {(W-1){1'b0}}} : {sgn, e[EXP_W-1:0], man};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sgn <= 1'b0;
            zero <= 1'b0;
            ea <= '0;
            eb <= '0;
            ma <= '0;
            mb <= '0;
            acc <= '0;
            cnt <= '0;
            product <= '0;
            underflow <= 1'b0;
            overflow <= 1'b0;
            inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sgn <= opA[W-1] ^ opB[W-1];
                    zero <= (opA[W-2:0] == '0) || (opB[W-2:0] == '0);
                    ea <= opA[W-2 -: EXP_W];
                    eb <= opB[W-2 -: EXP_W];
                    ma <= {1'b1, opA[MAN_W-1:0]};
                    mb <= {1'b1, opB[MAN_W-1:0]};
                    acc <= '0;
                    cnt <= '0;
                end
                MUL: begin
                    if (mb[cnt]) acc <= acc + (PW'(ma) << cnt);
                    cnt <= cnt + 4'd1;
                end
                NORM: begin
                    product <= res;
                    overflow <= !zero && ovf;
                    underflow <= !zero && !ovf && unf;
                    inexact <= !zero && dropped;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed fp16 multiply vectors with hand-computed results,
// latency, backpressure and mid-operation reset checks.
module tb_fp_mul_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [15:0] opA = '0;
    logic [15:0] opB = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [15:0] product;
    logic underflow, overflow, inexact;
    int errors = 0;
    int checks = 0;

    fp_mul_seq dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opA(opA), .opB(opB), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .underflow(underflow), .overflow(overflow), .inexact(inexact)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ep is the expected product; flags are {underflow, overflow, inexact}
    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ep, input logic [2:0] ef, input int hold);
        int lat;
        logic busy_ok;
        @(negedge clock);
        in_valid = 1'b1;
        opA = a;
        opB = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        opA = ~a;
        opB = ~b;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            busy_ok &= !in_ready;
            @(posedge clock);
            #1;
            lat++;
        end
        busy_ok &= !in_ready;
        chk({tag, "_latency"}, 32'(lat), 32'd12);
        chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
        chk({tag, "_product"}, 32'(product), 32'(ep));
        chk({tag, "_flags"}, 32'({underflow, overflow, inexact}), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            chk({tag, "_hold"}, 32'({out_valid, in_ready, product, underflow, overflow, inexact}),
                32'({1'b1, 1'b0, ep, ef}));
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk({tag, "_release"}, 32'({out_valid, in_ready}), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", 32'({in_ready, out_valid, product, underflow, overflow, inexact}),
            32'({1'b1, 1'b0, 16'h0000, 3'b000}));
        @(negedge clock);
        reset = 1'b0;
        op("mul_2x3", 16'h4000, 16'h4200, 16'h4600, 3'b000, 0);
        op("norm_up", 16'h3E00, 16'h3E00, 16'h4080, 3'b000, 0);
        op("sign", 16'hBC00, 16'h3C00, 16'hBC00, 3'b000, 0);
        op("inexact", 16'h3C01, 16'h3C01, 16'h3C02, 3'b001, 0);
        op("zero_a", 16'h0000, 16'h4000, 16'h0000, 3'b000, 0);
        op("neg_zero", 16'h8000, 16'h4000, 16'h8000, 3'b000, 0);
        op("overflow", 16'h7800, 16'h4000, 16'h7C00, 3'b010, 0);
        op("underflow", 16'h0400, 16'h3800, 16'h0000, 3'b100, 0);
        op("ovf_inexact", 16'h7BFF, 16'h7BFF, 16'h7C00, 3'b011, 0);
        op("unf_inexact", 16'h83FF, 16'h03FF, 16'h8000, 3'b101, 0);
        op("backpressure", 16'h3E00, 16'h3E00, 16'h4080, 3'b000, 5);
        op("b2b_1", 16'h4000, 16'h4200, 16'h4600, 3'b000, 0);
        op("b2b_2", 16'hBC00, 16'h3C00, 16'hBC00, 3'b000, 0);
        @(negedge clock);
        in_valid = 1'b1;
        opA = 16'h4000;
        opB = 16'h4200;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_reset", 32'({out_valid, in_ready, product}), 32'({1'b0, 1'b1, 16'h0000}));
        @(negedge clock);
        reset = 1'b0;
        op("after_reset", 16'h4000, 16'h4000, 16'h4400, 3'b000, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
